// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag controller of the async FIFO.
// Tracks binary/Gray write pointers and derives full, almost-full, level and overflow.
module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam logic [ADDRSIZE+1:0] AF_LVL = AFULL_THRESH[ADDRSIZE+1:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] count_next;
    logic              wfull_val;
    logic              wafull_val;

    assign wclken = winc & ~wfull;
    assign waddr  = wbin[ADDRSIZE-1:0];

    assign wbinnext  = wbin + (ADDRSIZE+1)'(wclken);
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    assign count_next = wbinnext - rbin_s;
    assign wafull_val = {1'b0, count_next} >= AF_LVL;
    assign wfull_val  = (wgraynext ==
                         {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                          wq2_rptr[ADDRSIZE-2:0]});

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wcount <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= wfull_val;
            wafull <= wafull_val;
            wcount <= count_next;
            if (winc & wfull) begin
                wovf <= 1'b1;
            end else if (wovf_clr) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl.
// Reference model counts total words written and read as plain integers.
module tb_wptr_full_ctrl;

    localparam int AS    = 4;
    localparam int DEPTH = 16;
    localparam int TH    = 12;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic          wovf_clr;
    logic [AS:0]   wq2_rptr;
    logic          wclken;
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AS:0]   wcount;
    logic          wovf;

    int tests = 0;
    int fails = 0;

    int m_wr, m_rd, m_cnt;
    bit m_full, m_ovf;
    int d1, d2, rd;

    wptr_full_ctrl #(.ADDRSIZE(AS), .AFULL_THRESH(TH)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .winc     (winc),
        .wovf_clr (wovf_clr),
        .wq2_rptr (wq2_rptr),
        .wclken   (wclken),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wcount   (wcount),
        .wovf     (wovf)
    );

    always #5 wclk = ~wclk;

    function automatic logic [AS:0] gray(int n);
        logic [AS:0] b;
        b = n[AS:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr   = 0;
        m_rd   = 0;
        m_cnt  = 0;
        m_full = 0;
        m_ovf  = 0;
    endtask

    // One wclk cycle: drive, check combinational outputs, clock, check state.
    task automatic cyc(bit inc, bit clr, int r);
        winc     = inc;
        wovf_clr = clr;
        wq2_rptr = gray(r);
        #1;
        chk("wclken", 32'(wclken), 32'(inc && !m_full));
        chk("waddr_pre", 32'(waddr), m_wr % DEPTH);
        @(posedge wclk);
        if (inc && m_full) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (inc && !m_full) m_wr++;
        m_rd   = r;
        m_cnt  = m_wr - r;
        m_full = (m_cnt == DEPTH);
        #1;
        chk("wptr", 32'(wptr), 32'(gray(m_wr)));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("wafull", 32'(wafull), 32'(m_cnt >= TH));
        chk("wcount", 32'(wcount), m_cnt);
        chk("wovf", 32'(wovf), 32'(m_ovf));
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_wptr"}, 32'(wptr), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wfull"}, 32'(wfull), 0);
        chk({tag, "_wafull"}, 32'(wafull), 0);
        chk({tag, "_wcount"}, 32'(wcount), 0);
        chk({tag, "_wovf"}, 32'(wovf), 0);
    endtask

    initial begin
        wrst     = 1'b1;
        winc     = 1'b1;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        model_reset();
        repeat (3) @(posedge wclk);
        #1;
        chk_reset_vals("rst");
        @(negedge wclk);
        wrst = 1'b0;
        @(posedge wclk);
        #1;
        // that edge already accepted one write (winc held high)
        m_wr   = 1;
        m_cnt  = 1;
        chk("first_wcount", 32'(wcount), 1);
        chk("first_wptr", 32'(wptr), 32'(gray(1)));

        // restart cleanly so the fill begins at waddr 0
        wrst = 1'b1;
        #1;
        model_reset();
        chk_reset_vals("rst2");
        @(negedge wclk);
        wrst = 1'b0;
        winc = 1'b0;
        @(posedge wclk);
        #1;

        // fill from empty
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 0, 0);
            if (i == TH - 2) chk("afull_before", 32'(wafull), 0);
            if (i == TH - 1) chk("afull_at12", 32'(wafull), 1);
        end
        chk("full_gray", 32'(wptr), 32'(5'b11000));
        chk("full_cnt", 32'(wcount), DEPTH);

        // overflow while full
        repeat (3) cyc(1, 0, 0);
        chk("ovf_ptr_hold", 32'(wptr), 32'(5'b11000));
        cyc(1, 1, 0);
        chk("ovf_set_wins", 32'(wovf), 1);
        cyc(0, 1, 0);
        chk("ovf_clr", 32'(wovf), 0);

        // drain release
        cyc(0, 0, 1);
        chk("drain_full", 32'(wfull), 0);
        chk("drain_cnt", 32'(wcount), 15);
        cyc(1, 0, 1);
        chk("refill_full", 32'(wfull), 1);

        // randomized traffic
        rd = m_rd;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3) != 0 && rd < m_wr) rd++;
            cyc(1'($urandom % 4 != 0), 1'($urandom % 8 == 0), rd);
        end

        // wrap with a reader that follows the writer through a 2-cycle sync
        d1 = m_rd;
        d2 = m_rd;
        for (int i = 0; i < 48; i++) begin
            cyc(1, 0, d2);
            d2 = d1;
            d1 = m_wr;
            if (i > 4) begin
                chk("wrap_nofull", 32'(wfull), 0);
                chk("wrap_cnt_le2", 32'(wcount <= 2), 1);
            end
        end

        // reset mid-operation with wcount=9 and wovf=1
        rd = m_wr;
        cyc(0, 1, rd);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, rd);
        cyc(1, 0, rd);
        cyc(0, 0, m_wr - 9);
        chk("pre_rst_cnt", 32'(wcount), 9);
        chk("pre_rst_ovf", 32'(wovf), 1);
        #2;
        wrst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        @(negedge wclk);
        wrst = 1'b0;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
